// File: rtl/ha_array_seq_accum.sv
// Sequencing controller for the 8x8 approximate multiplier front-end.
// It accepts one operand pair, latches the pair for the combinational
// front-end, and captures the four half-adder row pairs. It then folds those
// rows into a 17-bit accumulator through one shared adder over several cycles,
// and hands out a saturated 16-bit product.
module ha_array_seq_accum #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  output logic [7:0]  mul_x,
  output logic [7:0]  mul_y,
  input  logic [6:0]  ha_array_0_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [6:0]  ha_array_1_b,
  input  logic [8:0]  ha_array_1_t,
  input  logic [6:0]  ha_array_2_b,
  input  logic [8:0]  ha_array_2_t,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_3_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        out_sat,
  output logic        busy
);

  // Number of accumulation cycles, and the step index of the final add.
  localparam int         NUM_STEPS = 4 / ROWS_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, DONE} state_t;

  state_t      state;
  logic [11:0] row_buf [4];
  logic [11:0] row_now [4];
  logic [16:0] acc;
  logic [16:0] add_term;
  logic [16:0] acc_next;
  logic [1:0]  step;

  // Weight each front-end row pair into one 12-bit row value (t + 4*b).
  always_comb begin
    row_now[0] = {3'b000, ha_array_0_t} + {3'b000, ha_array_0_b, 2'b00};
    row_now[1] = {3'b000, ha_array_1_t} + {3'b000, ha_array_1_b, 2'b00};
    row_now[2] = {3'b000, ha_array_2_t} + {3'b000, ha_array_2_b, 2'b00};
    row_now[3] = {3'b000, ha_array_3_t} + {3'b000, ha_array_3_b, 2'b00};
  end

  // Sum the buffered rows that belong to the current step, each at its 4^i weight.
  always_comb begin
    add_term = '0;
    for (int j = 0; j < 4; j++) begin
      if (2'(j / ROWS_PER_CYCLE) == step) begin
        add_term = add_term + ({5'b00000, row_buf[j]} << (2 * j));
      end
    end
    acc_next = acc + add_term;
  end

  // Handshake sequencing, row capture and accumulation with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
      acc       <= '0;
      step      <= '0;
      for (int i = 0; i < 4; i++) begin
        row_buf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_x    <= in_x;
            mul_y    <= in_y;
            acc      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          for (int i = 0; i < 4; i++) begin
            row_buf[i] <= row_now[i];
          end
          step  <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          acc  <= acc_next;
          step <= step + 2'd1;
          if (step == LAST_STEP) begin
            out_valid <= 1'b1;
            out_sat   <= acc_next[16];
            out_p     <= acc_next[16] ? 16'hFFFF : acc_next[15:0];
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_array_seq_accum.sv
// Bench for ha_array_seq_accum: three instances (1, 2 and 4 rows per cycle)
// share one stimulus stream, with the row inputs driven directly in place of
// the front-end. Products are predicted from the row-weighting rule with plain
// integer arithmetic.
module tb_ha_array_seq_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        out_ready;
  logic [6:0]  b_in [4];
  logic [8:0]  t_in [4];

  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_sat   [3];
  logic        busy      [3];
  logic [15:0] out_p     [3];
  logic [7:0]  mul_x     [3];
  logic [7:0]  mul_y     [3];

  int steps_of [3] = '{4, 2, 1};
  int err_count;
  int check_count;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ha_array_seq_accum #(.ROWS_PER_CYCLE(1)) dut_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_x(in_x), .in_y(in_y), .mul_x(mul_x[0]), .mul_y(mul_y[0]),
    .ha_array_0_b(b_in[0]), .ha_array_0_t(t_in[0]),
    .ha_array_1_b(b_in[1]), .ha_array_1_t(t_in[1]),
    .ha_array_2_b(b_in[2]), .ha_array_2_t(t_in[2]),
    .ha_array_3_b(b_in[3]), .ha_array_3_t(t_in[3]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_p(out_p[0]),
    .out_sat(out_sat[0]), .busy(busy[0])
  );

  ha_array_seq_accum #(.ROWS_PER_CYCLE(2)) dut_r2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_x(in_x), .in_y(in_y), .mul_x(mul_x[1]), .mul_y(mul_y[1]),
    .ha_array_0_b(b_in[0]), .ha_array_0_t(t_in[0]),
    .ha_array_1_b(b_in[1]), .ha_array_1_t(t_in[1]),
    .ha_array_2_b(b_in[2]), .ha_array_2_t(t_in[2]),
    .ha_array_3_b(b_in[3]), .ha_array_3_t(t_in[3]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_p(out_p[1]),
    .out_sat(out_sat[1]), .busy(busy[1])
  );

  ha_array_seq_accum #(.ROWS_PER_CYCLE(4)) dut_r4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_x(in_x), .in_y(in_y), .mul_x(mul_x[2]), .mul_y(mul_y[2]),
    .ha_array_0_b(b_in[0]), .ha_array_0_t(t_in[0]),
    .ha_array_1_b(b_in[1]), .ha_array_1_t(t_in[1]),
    .ha_array_2_b(b_in[2]), .ha_array_2_t(t_in[2]),
    .ha_array_3_b(b_in[3]), .ha_array_3_t(t_in[3]),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_p(out_p[2]),
    .out_sat(out_sat[2]), .busy(busy[2])
  );

  // One counted comparison, reported on mismatch.
  task automatic checkOutput(input string tag, input int k,
                             input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      err_count++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, k, observed, expected);
    end
  endtask

  // Loads every row pair with the same t and b values.
  task automatic setRows(input logic [8:0] t, input logic [6:0] b);
    for (int i = 0; i < 4; i++) begin
      t_in[i] = t;
      b_in[i] = b;
    end
  endtask

  // Loads every row pair with random values.
  task automatic randomRows();
    for (int i = 0; i < 4; i++) begin
      t_in[i] = 9'($urandom);
      b_in[i] = 7'($urandom);
    end
  endtask

  // Runs one operand through all instances. The product is predicted from the
  // rows present at the load edge. The rows are then scrambled, junk operands
  // are offered while busy, and the result is held for 'hold' extra cycles
  // before being taken.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input int hold);
    int          sum;
    logic [15:0] exp_p;
    logic        exp_sat;
    bit          exp_valid;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      sum += (int'(t_in[i]) + 4 * int'(b_in[i])) * (1 << (2 * i));
    end
    exp_sat = (sum > 65535);
    exp_p   = exp_sat ? 16'hFFFF : sum[15:0];

    for (int k = 0; k < 3; k++) checkOutput("idle_in_ready", k, 32'(in_ready[k]), 32'd1);
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_x = 8'($urandom);
    in_y = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      checkOutput("accept_mul_x", k, 32'(mul_x[k]), 32'(x));
      checkOutput("accept_mul_y", k, 32'(mul_y[k]), 32'(y));
      checkOutput("load_busy", k, 32'(busy[k]), 32'd1);
      checkOutput("load_in_ready", k, 32'(in_ready[k]), 32'd0);
    end
    @(posedge clk); #1;
    randomRows();
    for (int e = 2; e <= 5 + hold; e++) begin
      @(posedge clk); #1;
      if (e == 2) in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        exp_valid = (e >= steps_of[k] + 1);
        checkOutput("out_valid_timing", k, 32'(out_valid[k]), 32'(exp_valid));
        checkOutput("busy_in_ready", k, 32'(in_ready[k]), 32'd0);
        checkOutput("busy_flag", k, 32'(busy[k]), 32'd1);
        if (exp_valid) begin
          checkOutput("out_p", k, 32'(out_p[k]), 32'(exp_p));
          checkOutput("out_sat", k, 32'(out_sat[k]), 32'(exp_sat));
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("after_take_valid", k, 32'(out_valid[k]), 32'd0);
      checkOutput("after_take_in_ready", k, 32'(in_ready[k]), 32'd1);
      checkOutput("after_take_busy", k, 32'(busy[k]), 32'd0);
      checkOutput("after_take_p_kept", k, 32'(out_p[k]), 32'(exp_p));
      checkOutput("after_take_sat_kept", k, 32'(out_sat[k]), 32'(exp_sat));
      checkOutput("mul_x_ignored_junk", k, 32'(mul_x[k]), 32'(x));
    end
  endtask

  // Directed sequence: reset, boundary products, random rows, reset mid-run.
  initial begin
    err_count   = 0;
    check_count = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    setRows(9'd0, 7'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("reset_in_ready", k, 32'(in_ready[k]), 32'd1);
      checkOutput("reset_out_valid", k, 32'(out_valid[k]), 32'd0);
      checkOutput("reset_out_p", k, 32'(out_p[k]), 32'd0);
      checkOutput("reset_busy", k, 32'(busy[k]), 32'd0);
      checkOutput("reset_mul_x", k, 32'(mul_x[k]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] unit rows, expecting 85");
    setRows(9'd1, 7'd0);
    applyStimulus(8'd3, 8'd3, 10);

    $display("[TB] all-ones rows, expecting saturation");
    setRows(9'h1FF, 7'h7F);
    applyStimulus(8'hFF, 8'hFF, 2);

    $display("[TB] single-row product 4");
    setRows(9'd0, 7'd0);
    t_in[0] = 9'd4;
    applyStimulus(8'd4, 8'd1, 0);

    for (int n = 0; n < 6; n++) begin
      randomRows();
      applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] reset during accumulation");
    setRows(9'd100, 7'd20);
    in_x     = 8'd9;
    in_y     = 8'd7;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("midrun_reset_valid", k, 32'(out_valid[k]), 32'd0);
      checkOutput("midrun_reset_p", k, 32'(out_p[k]), 32'd0);
      checkOutput("midrun_reset_in_ready", k, 32'(in_ready[k]), 32'd1);
      checkOutput("midrun_reset_busy", k, 32'(busy[k]), 32'd0);
    end
    rst = 1'b0;
    setRows(9'd0, 7'd0);
    t_in[0] = 9'd4;
    applyStimulus(8'd4, 8'd1, 1);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/ha_array_seq_accum.md
Name: ha_array_seq_accum

Overview:
- Sequencing controller for the unsigned 8x8 approximate multiplier front-end. That front-end is combinational and produces four half-adder-compressed row pairs (b 7-bit, t 9-bit each).
- This block accepts operands over a valid/ready handshake and drives them to the front-end. It captures the four row pairs, then reduces them through one shared row adder over several cycles.
- It presents the 16-bit product over a valid/ready handshake.
- It sits between the operand source and the result consumer, replacing a full single-cycle final adder.

Parameters:
- ROWS_PER_CYCLE, 1, rows added per accumulation cycle; legal values 1, 2, 4; N = 4/ROWS_PER_CYCLE accumulation cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_x  input  8  multiplicand.
- in_y  input  8  multiplier.
- mul_x  output  8  registered operand x to the front-end.
- mul_y  output  8  registered operand y to the front-end.
- ha_array_i_b, i=0..3  input  7 each  front-end carry rows.
- ha_array_i_t, i=0..3  input  9 each  front-end sum rows.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_p  output  16  product, saturated.
- out_sat  output  1  accumulator exceeded 16 bits.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) forces these values, regardless of state, including mid-ACCUM or mid-DONE:
  - state=IDLE, in_ready=1, out_valid=0, out_p=0, out_sat=0, busy=0, mul_x=0, mul_y=0.
  - accumulator=0, row counter=0.
  - Any in-flight operation is discarded with no output.
- Row weighting: row_i = t_i + (b_i << 2), 12-bit value. Row i contributes row_i << (2*i).
- Accumulator width is 17 bits, zero-extended adds, no wrap.
- States are IDLE, LOAD, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_x/in_y into mul_x/mul_y, clear the accumulator, go to LOAD.
- LOAD (1 cycle):
  - in_ready=0. The front-end settles on mul_x/mul_y.
  - At the edge, capture all eight row vectors into a row buffer, counter=0, go to ACCUM.
  - Front-end inputs are sampled only at this edge; later changes are ignored.
- ACCUM (N cycles):
  - Each edge adds ROWS_PER_CYCLE consecutive buffered rows, starting at row 2*... index counter*ROWS_PER_CYCLE, each shifted by 2*i, into the accumulator. The counter then increments.
  - After the N-th add, go to DONE.
- DONE:
  - out_valid=1.
  - out_p = acc[15:0] if acc[16]==0, else 16'hFFFF.
  - out_sat = acc[16].
  - out_p and out_sat are stable while out_valid=1 and out_ready=0 (hold indefinitely).
  - On out_valid & out_ready: go to IDLE. out_valid drops next cycle, and out_p/out_sat keep their last value.
- No overlap: in_ready=0 in LOAD, ACCUM and DONE. An operand is never accepted in the same cycle a result is taken.
- Latency: with the accept edge as edge 0, out_valid rises after edge N+1. That is edge 5 (R=1), edge 3 (R=2), edge 2 (R=4).
- Throughput: one product per N+3 cycles with out_ready held high.
- in_valid while in_ready=0 is ignored; no buffering.

Test Plan:
- Real front-end connected, R=1, x=3, y=3, out_ready=1: out_p=5 (approximate; x0y1/x1y0 eliminated), out_sat=0, out_valid after edge 5, busy high edges 1-5.
- Real front-end, x=2, y=1, then x=4, y=1: first out_p=0 (x1y0 eliminated), second out_p=4. in_ready is low between accept and result handoff.
- Rows driven directly, all t=9'h1FF and all b=7'h7F, R=1: row=1019, acc=86615 -> out_p=16'hFFFF, out_sat=1.
- Rows driven directly (t_i=1, b_i=0, all i), R=1, 2 and 4: out_p=85 for all, with out_valid after edges 5, 3 and 2 respectively. Hold out_ready=0 for 10 cycles: out_p stable, out_valid stays high, in_ready stays 0. In the R=1 run, change the row inputs after the LOAD edge: result unchanged.
- Assert rst during ACCUM (edge 3), in_valid held high: next cycle state IDLE, out_valid=0, out_p=0, in_ready=1. A new operand x=4, y=1 then completes with out_p=4.
